// File: rtl/ovl_fire_pkg.sv
// Shared constants for the OVL fire collector: fire-vector layout and the
// report state encoding.
package ovl_fire_pkg;

  localparam int unsigned FIRE_W      = 3;
  localparam int unsigned FIRE_ASSERT = 0;
  localparam int unsigned FIRE_XCHECK = 1;
  localparam int unsigned FIRE_COVER  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_t;

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin grant: scans the request vector starting at
// i_start and returns the first requester as one-hot and as an index.
module ovl_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int unsigned w_pos;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // wrap without a modulo so non-power-of-two N stays cheap
      w_pos = 32'(i_start) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IW'(w_pos);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/ovl_fire_arbiter.sv
// Collects per-checker OVL fire vectors into pending registers and reports
// them one at a time over a valid/ready port, round-robin across checkers.
module ovl_fire_arbiter
  import ovl_fire_pkg::*;
#(
  parameter int unsigned num_checkers = 4,
  parameter int unsigned cnt_width    = 16,
  parameter string       msg          = "VIOLATION"
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [num_checkers*FIRE_W-1:0]   fire_in,
  input  logic                             rpt_ready,
  output logic                             rpt_valid,
  output logic [$clog2(num_checkers)-1:0]  rpt_id,
  output logic [FIRE_W-1:0]                rpt_fire,
  output logic [num_checkers-1:0]          pending,
  output logic [cnt_width-1:0]             coalesce_cnt
);

  localparam int unsigned ID_W = $clog2(num_checkers);

  state_t                              r_state, w_state_nxt;
  logic [num_checkers-1:0][FIRE_W-1:0] r_pend, w_pend_nxt, w_cap;
  logic [ID_W-1:0]                     r_id, r_ptr, w_gnt_idx;
  logic [FIRE_W-1:0]                   r_fire;
  logic [cnt_width-1:0]                r_cnt, w_cnt_nxt;
  logic [num_checkers-1:0]             w_req, w_gnt;
  logic                                w_any, w_do_grant;
  logic [4:0]                          w_ncoal;
  logic [cnt_width+4:0]                w_cnt_sum;

  always_comb begin
    for (int unsigned i = 0; i < num_checkers; i++) begin
      w_cap[i] = enable ? fire_in[i*FIRE_W +: FIRE_W] : '0;
      w_req[i] = |r_pend[i];
    end
  end

  ovl_rr_arbiter #(
    .N  (num_checkers),
    .IW (ID_W)
  ) u_rr (
    .i_req   (w_req),
    .i_start (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = REPORT;
          w_do_grant  = 1'b1;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          if (w_any) w_do_grant  = 1'b1;
          else       w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // A granted entry restarts from this cycle's capture, so a same-edge fire
  // is kept for a later report and does not count as coalesced.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ncoal    = '0;
    for (int unsigned i = 0; i < num_checkers; i++) begin
      if (w_do_grant && w_gnt[i]) begin
        w_pend_nxt[i] = w_cap[i];
      end else begin
        w_pend_nxt[i] = r_pend[i] | w_cap[i];
        if (w_req[i] && (|w_cap[i])) w_ncoal = w_ncoal + 5'd1;
      end
    end
    w_cnt_sum = {5'd0, r_cnt} + (cnt_width+5)'(w_ncoal);
    w_cnt_nxt = (|w_cnt_sum[cnt_width+4:cnt_width]) ? '1 : w_cnt_sum[cnt_width-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_fire  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_do_grant) begin
        r_id   <= w_gnt_idx;
        r_fire <= r_pend[w_gnt_idx];
        r_ptr  <= (w_gnt_idx == ID_W'(num_checkers-1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign rpt_valid    = (r_state == REPORT);
  assign rpt_id       = r_id;
  assign rpt_fire     = r_fire;
  assign coalesce_cnt = r_cnt;

  always_comb begin
    for (int unsigned i = 0; i < num_checkers; i++) pending[i] = |r_pend[i];
  end

`ifndef SYNTHESIS
  a_hold_stalled: assert property (@(posedge clock) disable iff (!reset)
    (rpt_valid && !rpt_ready) |=> (rpt_valid && $stable(rpt_id) && $stable(rpt_fire)))
    else $error("%s: report changed while stalled", msg);
`endif

endmodule

// File: tb/tb_ovl_fire_arbiter.sv
// Scoreboard bench for ovl_fire_arbiter: a rule-level model predicts each
// report, a monitor pops and compares on every accepted handshake.
module tb_ovl_fire_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 5;
  localparam int unsigned IW   = 2;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [N*3-1:0]  fire_in;
  logic            rpt_ready;
  logic            rpt_valid;
  logic [IW-1:0]   rpt_id;
  logic [2:0]      rpt_fire;
  logic [N-1:0]    pending;
  logic [CW-1:0]   coalesce_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ovl_fire_arbiter #(
    .num_checkers (N),
    .cnt_width    (CW),
    .msg          ("TBCHK")
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .fire_in      (fire_in),
    .rpt_ready    (rpt_ready),
    .rpt_valid    (rpt_valid),
    .rpt_id       (rpt_id),
    .rpt_fire     (rpt_fire),
    .pending      (pending),
    .coalesce_cnt (coalesce_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-checker pending bit-sets, next-search pointer,
  // coalesce tally and the report currently on offer.
  int unsigned m_pend[N];
  int unsigned m_ptr, m_cnt, m_valid, m_id, m_fire, m_slice, m_idx;
  int          m_g;
  int unsigned exp_q[$];

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_pend[i] != 0);
    return v;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_cnt = 0; m_valid = 0; m_id = 0; m_fire = 0;
      exp_q.delete();
    end else begin
      m_g = -1;
      if (m_valid == 0 || rpt_ready) begin
        m_valid = 0;
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (m_g < 0 && m_pend[m_idx] != 0) m_g = m_idx;
        end
        if (m_g >= 0) begin
          m_valid = 1;
          m_id    = m_g;
          m_fire  = m_pend[m_g];
          m_pend[m_g] = 0;
          m_ptr   = (m_g + 1) % N;
          exp_q.push_back(m_id * 8 + m_fire);
        end
      end
      if (enable) begin
        for (int i = 0; i < N; i++) begin
          m_slice = fire_in[3*i +: 3];
          if (m_slice != 0) begin
            if (m_pend[i] != 0) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
            m_pend[i] = m_pend[i] | m_slice;
          end
        end
      end
    end
  end

  // Monitor: outputs are stable at negedge; inputs change only at posedge+1.
  int unsigned mon_e;
  always @(negedge clock) begin
    if (reset) begin
      chk("valid", rpt_valid, m_valid);
      chk("pending", pending, model_pending());
      chk("coalesce", coalesce_cnt, m_cnt);
      if (rpt_valid && rpt_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_report", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_id", rpt_id, mon_e / 8);
          chk("sb_fire", rpt_fire, mon_e % 8);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0; enable = 1'b0; fire_in = '0; rpt_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; fire_in = '0; rpt_ready = 1'b0;
    step(); step(); step();
    chk("rst_valid", rpt_valid, 0);
    chk("rst_id", rpt_id, 0);
    chk("rst_fire", rpt_fire, 0);
    chk("rst_pending", pending, 0);
    chk("rst_coalesce", coalesce_cnt, 0);
    reset = 1'b1;

    // single fire, one-cycle latency
    do_reset();
    enable = 1'b1; rpt_ready = 1'b1; fire_in = 12'h040;
    step(); fire_in = '0;
    chk("d32_pend", pending, 4'b0100);
    chk("d32_idle", rpt_valid, 0);
    step();
    chk("d32_valid", rpt_valid, 1);
    chk("d32_id", rpt_id, 2);
    chk("d32_fire", rpt_fire, 3'b001);
    step();
    chk("d32_done", rpt_valid, 0);

    // three simultaneous fires, back-to-back reports
    do_reset();
    enable = 1'b1; rpt_ready = 1'b1; fire_in = 12'h209;
    step(); fire_in = '0;
    step(); chk("d33_id0", rpt_id, 0); chk("d33_v0", rpt_valid, 1);
    step(); chk("d33_id1", rpt_id, 1); chk("d33_v1", rpt_valid, 1);
    step(); chk("d33_id3", rpt_id, 3); chk("d33_v3", rpt_valid, 1);
    step(); chk("d33_done", rpt_valid, 0);

    // coalescing behind a stalled report from checker 0
    do_reset();
    enable = 1'b1; rpt_ready = 1'b0; fire_in = 12'h001;
    step(); fire_in = 12'h008;
    step(); fire_in = 12'h010;
    step();
    step(); fire_in = '0;
    chk("d34_cnt", coalesce_cnt, 2);
    chk("d34_pend", pending, 4'b0010);
    chk("d34_id0", rpt_id, 0);
    rpt_ready = 1'b1;
    step();
    chk("d34_id1", rpt_id, 1);
    chk("d34_fire", rpt_fire, 3'b011);
    step();
    chk("d34_done", rpt_valid, 0);
    chk("d34_cnt_hold", coalesce_cnt, 2);

    // fire on the grant edge gives a second report, no coalesce
    do_reset();
    enable = 1'b1; rpt_ready = 1'b1; fire_in = 12'h004;
    step();
    step(); fire_in = '0;
    chk("d35_id_a", rpt_id, 0);
    chk("d35_fire_a", rpt_fire, 3'b100);
    chk("d35_pend", pending, 4'b0001);
    chk("d35_cnt_a", coalesce_cnt, 0);
    step();
    chk("d35_valid_b", rpt_valid, 1);
    chk("d35_id_b", rpt_id, 0);
    chk("d35_fire_b", rpt_fire, 3'b100);
    chk("d35_cnt_b", coalesce_cnt, 0);
    step();
    chk("d35_done", rpt_valid, 0);

    // enable low blocks all capture
    do_reset();
    enable = 1'b0; fire_in = '1;
    for (int c = 0; c < 10; c++) begin
      rpt_ready = 1'($urandom_range(0, 1));
      step();
      chk("d36_pend", pending, 0);
      chk("d36_valid", rpt_valid, 0);
    end
    fire_in = '0;

    // reset mid-report discards everything
    do_reset();
    enable = 1'b1; rpt_ready = 1'b0; fire_in = 12'h249;
    step(); fire_in = '0;
    step();
    chk("d37_pre_valid", rpt_valid, 1);
    chk("d37_pre_pend", pending, 4'b1110);
    reset = 1'b0;
    #1;
    chk("d37_valid", rpt_valid, 0);
    chk("d37_id", rpt_id, 0);
    chk("d37_fire", rpt_fire, 0);
    chk("d37_pend", pending, 0);
    chk("d37_cnt", coalesce_cnt, 0);
    step(); step();
    reset = 1'b1; rpt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("d37_noreport", rpt_valid, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      rpt_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++)
        fire_in[3*i +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end

    // drain remaining events
    enable = 1'b0; fire_in = '0; rpt_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", rpt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
